// File: rtl/decode_stage.sv
// LC-3b decode stage: instruction decode, register file with write-first
// bypass from write-back, per-register pending-write scoreboard for RAW
// hazards, and a single registered output slot toward execute.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps valid and payload stable until ready; ready
// never depends combinationally on the same port's valid (if_ready only
// consults if_valid through the hazard term, which gates acceptance alone).
module decode_stage #(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int SB_W  = 2,
  localparam int RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [15:0]      if_instr,
  input  logic [WIDTH-1:0] if_pc,
  input  logic             wb_valid,
  input  logic [RW-1:0]    wb_dest,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [3:0]       ex_opcode,
  output logic [WIDTH-1:0] ex_pc,
  output logic [WIDTH-1:0] ex_sr1,
  output logic [WIDTH-1:0] ex_sr2,
  output logic [RW-1:0]    ex_dest,
  output logic             ex_wr,
  output logic [WIDTH-1:0] ex_imm,
  output logic             sb_err
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDW  = 4'b0110;
  localparam logic [3:0] OP_STW  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_SHF  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [RW-1:0] LINK_REG = RW'(7);

  logic [WIDTH-1:0] rf  [NREG];
  logic [SB_W-1:0]  cnt [NREG];

  logic [3:0]       op;
  logic [RW-1:0]    sr1_idx;
  logic [RW-1:0]    sr2_idx;
  logic             sr1_used;
  logic             sr2_used;
  logic [RW-1:0]    dest;
  logic             wr;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] sr1_val;
  logic [WIDTH-1:0] sr2_val;
  logic             hit1;
  logic             hit2;
  logic             busy1;
  logic             busy2;
  logic             sat;
  logic             stall;
  logic             accept;
  logic             ex_fire;

  // Field decode: sources, destination and immediate of the fetched word
  always_comb begin
    op       = if_instr[15:12];
    sr1_idx  = RW'(if_instr[8:6]);
    sr2_idx  = RW'(if_instr[2:0]);
    sr1_used = 1'b0;
    sr2_used = 1'b0;
    dest     = RW'(if_instr[11:9]);
    wr       = 1'b0;
    imm      = '0;
    case (op)
      OP_ADD, OP_AND: begin
        sr1_used = 1'b1;
        sr2_used = ~if_instr[5];
        wr       = 1'b1;
        imm      = WIDTH'($signed(if_instr[4:0]));
      end
      OP_NOT: begin
        sr1_used = 1'b1;
        wr       = 1'b1;
      end
      OP_LDB: begin
        sr1_used = 1'b1;
        wr       = 1'b1;
        imm      = WIDTH'($signed(if_instr[5:0]));
      end
      OP_LDW, OP_LDI: begin
        sr1_used = 1'b1;
        wr       = 1'b1;
        imm      = WIDTH'($signed(if_instr[5:0])) << 1;
      end
      OP_STB: begin
        sr1_used = 1'b1;
        sr2_used = 1'b1;
        sr2_idx  = RW'(if_instr[11:9]);
        imm      = WIDTH'($signed(if_instr[5:0]));
      end
      OP_STW, OP_STI: begin
        sr1_used = 1'b1;
        sr2_used = 1'b1;
        sr2_idx  = RW'(if_instr[11:9]);
        imm      = WIDTH'($signed(if_instr[5:0])) << 1;
      end
      OP_JMP: begin
        sr1_used = 1'b1;
      end
      OP_JSR: begin
        // bit 11 selects JSR (PC-relative) versus JSRR (base register)
        dest = LINK_REG;
        wr   = 1'b1;
        if (if_instr[11]) imm = WIDTH'($signed(if_instr[10:0])) << 1;
        else              sr1_used = 1'b1;
      end
      OP_SHF: begin
        sr1_used = 1'b1;
        wr       = 1'b1;
        imm      = WIDTH'(if_instr[3:0]);
      end
      OP_LEA: begin
        wr  = 1'b1;
        imm = WIDTH'($signed(if_instr[8:0])) << 1;
      end
      OP_BR: begin
        imm = WIDTH'($signed(if_instr[8:0])) << 1;
      end
      OP_TRAP: begin
        dest = LINK_REG;
        wr   = 1'b1;
        imm  = WIDTH'(if_instr[7:0]) << 1;
      end
      default: begin
      end
    endcase
  end

  // Operand read with write-first bypass and hazard / handshake evaluation
  always_comb begin
    hit1    = wb_valid && (wb_dest == sr1_idx);
    hit2    = wb_valid && (wb_dest == sr2_idx);
    sr1_val = hit1 ? wb_data : rf[sr1_idx];
    sr2_val = hit2 ? wb_data : rf[sr2_idx];
    // a write-back landing this cycle retires one of the pending writes
    busy1   = hit1 ? (cnt[sr1_idx] > SB_W'(1)) : (cnt[sr1_idx] != '0);
    busy2   = hit2 ? (cnt[sr2_idx] > SB_W'(1)) : (cnt[sr2_idx] != '0);
    sat     = wr && (cnt[dest] == '1);
    stall   = if_valid && ((sr1_used && busy1) || (sr2_used && busy2) || sat);
    if_ready = !stall && (!ex_valid || ex_ready) && !flush;
    accept  = if_valid && if_ready;
    ex_fire = ex_valid && ex_ready && !flush;
  end

  // Register file write from write-back
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) rf[r] <= '0;
    end else if (wb_valid) begin
      rf[wb_dest] <= wb_data;
    end
  end

  // Pending-write counters: +1 when EX takes a writer, -1 on write-back
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (ex_fire && ex_wr && (ex_dest == RW'(r)) &&
            !(wb_valid && (wb_dest == RW'(r)))) begin
          cnt[r] <= cnt[r] + SB_W'(1);
        end else if (wb_valid && (wb_dest == RW'(r)) &&
                     !(ex_fire && ex_wr && (ex_dest == RW'(r)))) begin
          if (cnt[r] == '0) sb_err <= 1'b1;
          else              cnt[r] <= cnt[r] - SB_W'(1);
        end
      end
    end
  end

  // Output slot toward execute: capture on accept, drain or kill otherwise
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid  <= 1'b0;
      ex_opcode <= '0;
      ex_pc     <= '0;
      ex_sr1    <= '0;
      ex_sr2    <= '0;
      ex_dest   <= '0;
      ex_wr     <= 1'b0;
      ex_imm    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid  <= 1'b1;
      ex_opcode <= op;
      ex_pc     <= if_pc;
      ex_sr1    <= sr1_val;
      ex_sr2    <= sr2_val;
      ex_dest   <= dest;
      ex_wr     <= wr;
      ex_imm    <= imm;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected outputs are queued as each
// instruction is issued and checked by a monitor on every EX handshake.
module tb_decode_stage;
  localparam int WIDTH = 16;
  localparam int NREG  = 8;
  localparam int SB_W  = 2;
  localparam int RW    = 3;
  localparam int EW    = 4 + 3 * WIDTH + RW + 1 + WIDTH;

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             if_valid;
  logic             if_ready;
  logic [15:0]      if_instr;
  logic [WIDTH-1:0] if_pc;
  logic             wb_valid;
  logic [RW-1:0]    wb_dest;
  logic [WIDTH-1:0] wb_data;
  logic             ex_valid;
  logic             ex_ready;
  logic [3:0]       ex_opcode;
  logic [WIDTH-1:0] ex_pc;
  logic [WIDTH-1:0] ex_sr1;
  logic [WIDTH-1:0] ex_sr2;
  logic [RW-1:0]    ex_dest;
  logic             ex_wr;
  logic [WIDTH-1:0] ex_imm;
  logic             sb_err;

  logic [EW-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  decode_stage #(.WIDTH(WIDTH), .NREG(NREG), .SB_W(SB_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_opcode(ex_opcode), .ex_pc(ex_pc),
    .ex_sr1(ex_sr1), .ex_sr2(ex_sr2), .ex_dest(ex_dest), .ex_wr(ex_wr),
    .ex_imm(ex_imm), .sb_err(sb_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [EW-1:0] mk(input logic [3:0] op, input logic [WIDTH-1:0] pc,
                                       input logic [WIDTH-1:0] s1, input logic [WIDTH-1:0] s2,
                                       input logic [RW-1:0] d, input logic w,
                                       input logic [WIDTH-1:0] im);
    return {op, pc, s1, s2, d, w, im};
  endfunction

  function automatic logic [EW-1:0] cur_out();
    return {ex_opcode, ex_pc, ex_sr1, ex_sr2, ex_dest, ex_wr, ex_imm};
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wb(input logic [RW-1:0] d, input logic [WIDTH-1:0] data);
    wb_valid = 1'b1;
    wb_dest  = d;
    wb_data  = data;
    step();
    wb_valid = 1'b0;
  endtask

  // present one instruction, wait (bounded) for if_ready, queue expectation
  task automatic issue(input logic [15:0] ins, input logic [WIDTH-1:0] pc,
                       input logic [EW-1:0] e, input bit push, input int max_wait,
                       output int waited);
    if_instr = ins;
    if_pc    = pc;
    if_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!if_ready && waited < max_wait) begin
      waited++;
      @(negedge clk);
    end
    if (!if_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout instr=%h waited=%0d", ins, waited);
      step();
      if_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(e);
    step();
    if_valid = 1'b0;
  endtask

  // scoreboard monitor: compare on each EX handshake, drop flushed entries
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset_n && ex_valid) begin
      if (flush) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end else if (ex_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ex_out act=%h exp=<none>", cur_out());
        end else begin
          e = exp_q.pop_front();
          if (cur_out() !== e) begin
            errors++;
            $display("FAIL ex_out act=%h exp=%h", cur_out(), e);
          end
        end
      end
    end
  end

  initial begin
    int w;
    logic [EW-1:0] lea_e;
    reset_n  = 1'b0;
    flush    = 1'b0;
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
    wb_valid = 1'b0;
    wb_dest  = '0;
    wb_data  = '0;
    ex_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    chk("rst_ex_valid", EW'(ex_valid), EW'(0));
    chk("rst_sb_err",   EW'(sb_err),   EW'(0));
    chk("rst_if_ready", EW'(if_ready), EW'(1));
    step();

    // back-to-back independent: ADD R1,R2,#3 then AND R4,R5,R6
    issue(16'h12A3, 16'h3002, mk(4'h1, 16'h3002, 16'h0000, 16'h0000, 3'd1, 1'b1, 16'h0003), 1, 4, w);
    issue(16'h5946, 16'h3004, mk(4'h5, 16'h3004, 16'h0000, 16'h0000, 3'd4, 1'b1, 16'h0006), 1, 4, w);
    chk("b2b_no_wait", EW'(w), EW'(0));
    idle(2);
    wb(3'd4, 16'h0055);

    // RAW: R1 pending, ADD R2,R1,R1 waits for the write-back of R1
    if_instr = 16'h1441;
    if_pc    = 16'h3008;
    if_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("raw_stall", EW'(if_ready), EW'(0));
    end
    step();
    wb_valid = 1'b1;
    wb_dest  = 3'd1;
    wb_data  = 16'h1234;
    @(negedge clk);
    chk("raw_release", EW'(if_ready), EW'(1));
    exp_q.push_back(mk(4'h1, 16'h3008, 16'h1234, 16'h1234, 3'd2, 1'b1, 16'h0001));
    step();
    if_valid = 1'b0;
    wb_valid = 1'b0;
    idle(2);
    wb(3'd2, 16'h2222);

    // backpressure: LEA R6,#-2 held while TRAP x25 waits
    ex_ready = 1'b0;
    lea_e = mk(4'hE, 16'h300A, 16'h0000, 16'h0000, 3'd6, 1'b1, 16'hFFFC);
    issue(16'hEDFE, 16'h300A, lea_e, 1, 4, w);
    if_instr = 16'hF025;
    if_pc    = 16'h300C;
    if_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ex_valid", EW'(ex_valid), EW'(1));
      chk("bp_hold",     cur_out(),     lea_e);
      chk("bp_if_ready", EW'(if_ready), EW'(0));
    end
    step();
    ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", EW'(if_ready), EW'(1));
    exp_q.push_back(mk(4'hF, 16'h300C, 16'h0000, 16'h0000, 3'd7, 1'b1, 16'h004A));
    step();
    if_valid = 1'b0;
    idle(2);
    wb(3'd6, 16'h0006);
    wb(3'd7, 16'h0777);

    // flush a held JSR; R7 must not become pending
    ex_ready = 1'b0;
    issue(16'h4805, 16'h3010, mk(4'h4, 16'h3010, 16'h0000, 16'h0000, 3'd7, 1'b1, 16'h000A), 1, 4, w);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_if_ready", EW'(if_ready), EW'(0));
    step();
    flush    = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("flush_ex_valid", EW'(ex_valid), EW'(0));
    step();
    issue(16'h11E0, 16'h3012, mk(4'h1, 16'h3012, 16'h0777, 16'h0000, 3'd0, 1'b1, 16'h0000), 1, 4, w);
    chk("flush_no_stall", EW'(w), EW'(0));
    idle(2);
    wb(3'd0, 16'h0BAD);

    // scoreboard saturation: three pending writers to R3 block a fourth
    for (int i = 0; i < 3; i++)
      issue(16'h1621, WIDTH'(16'h3014 + 2 * i),
            mk(4'h1, WIDTH'(16'h3014 + 2 * i), 16'h0BAD, 16'h1234, 3'd3, 1'b1, 16'h0001), 1, 4, w);
    idle(3);
    if_instr = 16'h1621;
    if_pc    = 16'h301A;
    if_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("sat_stall", EW'(if_ready), EW'(0));
    end
    step();
    wb_valid = 1'b1;
    wb_dest  = 3'd3;
    wb_data  = 16'h3333;
    @(negedge clk);
    chk("sat_wb_cycle", EW'(if_ready), EW'(0));
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("sat_release", EW'(if_ready), EW'(1));
    exp_q.push_back(mk(4'h1, 16'h301A, 16'h0BAD, 16'h1234, 3'd3, 1'b1, 16'h0001));
    step();
    if_valid = 1'b0;
    idle(2);

    // spurious write-back to R5 sets sticky sb_err
    @(negedge clk);
    chk("sb_err_before", EW'(sb_err), EW'(0));
    step();
    wb(3'd5, 16'h5555);
    @(negedge clk);
    chk("sb_err_set", EW'(sb_err), EW'(1));
    step();
    idle(2);
    @(negedge clk);
    chk("sb_err_sticky", EW'(sb_err), EW'(1));
    step();

    // reset mid-stall with a held output
    ex_ready = 1'b0;
    issue(16'h5946, 16'h301C, '0, 0, 4, w);
    if_instr = 16'h1621;
    if_pc    = 16'h3020;
    if_valid = 1'b1;
    @(negedge clk);
    chk("pre_reset_stall", EW'(if_ready), EW'(0));
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ex_valid", EW'(ex_valid), EW'(0));
    chk("post_reset_sb_err",   EW'(sb_err),   EW'(0));
    chk("post_reset_if_ready", EW'(if_ready), EW'(1));
    exp_q.push_back(mk(4'h1, 16'h3020, 16'h0000, 16'h0000, 3'd3, 1'b1, 16'h0001));
    step();
    if_valid = 1'b0;
    ex_ready = 1'b1;
    idle(3);

    chk("queue_empty", EW'(exp_q.size()), EW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
